// File: rtl/add_in_pkg_hdl.sv
// Shared types and default widths for the add_in adder family.
// Imported by the FIFO and the multi-channel accumulator top.
package add_in_pkg_hdl;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefAccWidth  = 16;
    localparam int unsigned DefNumCh     = 4;
    localparam int unsigned DefFifoDepth = 4;
    localparam int unsigned DefChWidth   = $clog2(DefNumCh);

    typedef enum logic [1:0] {
        ADD     = 2'd0,
        ADD_SAT = 2'd1,
        ACC     = 2'd2,
        CLR     = 2'd3
    } add_op_t;

    // Result record at default widths; the top re-declares it at its own widths.
    typedef struct packed {
        logic [DefChWidth-1:0]  ch;
        logic [DefAccWidth-1:0] sum;
        logic                   ovf;
    } add_res_t;

endpackage

// File: rtl/add_res_fifo.sv
// Synchronous FIFO of result records with push/pop, occupancy count and empty flag.
// Depth must be a power of two so the pointers wrap naturally.
module add_res_fifo
    import add_in_pkg_hdl::*;
#(
    parameter int unsigned Depth = DefFifoDepth,
    parameter type         T     = add_res_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  T                           data_i,
    input  logic                       pop_i,
    output T                           data_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] DepthC = CntW'(Depth);

    T                mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && ((count_q != DepthC) || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head stays at the slot after the last pop, so an empty FIFO shows stale data.
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/add_multi_ch_accum.sv
// Multi-channel adder/accumulator: one stage register, per-channel accumulators,
// credit-gated input and an output FIFO with valid/ready backpressure.
module add_multi_ch_accum
    import add_in_pkg_hdl::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ACC_WIDTH  = DefAccWidth,
    parameter int unsigned NUM_CH     = DefNumCh,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [$clog2(NUM_CH)-1:0] in_ch,
    input  logic [1:0]                in_op,
    input  logic [DATA_WIDTH-1:0]     in_a,
    input  logic [DATA_WIDTH-1:0]     in_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic [ACC_WIDTH-1:0]      out_sum,
    output logic                      out_ovf,
    output logic [NUM_CH-1:0]         acc_busy
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]       DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'({DATA_WIDTH{1'b1}});

    typedef struct packed {
        logic [CH_W-1:0]      ch;
        logic [ACC_WIDTH-1:0] sum;
        logic                 ovf;
    } res_t;

    res_t                 s1_q;
    res_t                 s1_d;
    logic                 s1_valid_q;
    res_t                 head;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_empty;
    logic [CNT_W:0]       inflight;
    logic                 accept;
    logic                 pop;
    add_op_t              op;
    logic [ACC_WIDTH-1:0] acc_q [NUM_CH];
    logic [ACC_WIDTH-1:0] acc_cur;
    logic [DATA_WIDTH:0]  sum_w;
    logic [ACC_WIDTH:0]   acc_w;
    logic [CNT_W-1:0]     busy_cnt_q [NUM_CH];

    // Credit from registered state only: a same-cycle pop never raises in_ready.
    assign inflight = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid_q};
    assign in_ready = (inflight < DEPTH_C);
    assign accept   = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign pop      = out_valid && out_ready;
    assign op       = add_op_t'(in_op);

    always_comb begin
        acc_cur = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (in_ch == CH_W'(c)) begin
                acc_cur = acc_q[c];
            end
        end
    end

    assign sum_w = {1'b0, in_a} + {1'b0, in_b};
    assign acc_w = (ACC_WIDTH + 1)'(acc_cur) + (ACC_WIDTH + 1)'(in_a);

    always_comb begin
        s1_d     = '0;
        s1_d.ch  = in_ch;
        unique case (op)
            ADD: begin
                s1_d.sum = ACC_WIDTH'(sum_w);
                s1_d.ovf = sum_w[DATA_WIDTH];
            end
            ADD_SAT: begin
                s1_d.sum = sum_w[DATA_WIDTH] ? SAT_MAX : ACC_WIDTH'(sum_w);
                s1_d.ovf = sum_w[DATA_WIDTH];
            end
            ACC: begin
                s1_d.sum = acc_w[ACC_WIDTH-1:0];
                s1_d.ovf = acc_w[ACC_WIDTH];
            end
            CLR: begin
                s1_d.sum = '0;
                s1_d.ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_q <= s1_d;
            end
        end
    end

    // Accumulators update on the accept edge, so back-to-back ACC needs no forwarding.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                acc_q[c] <= '0;
            end
        end else if (accept) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (in_ch == CH_W'(c)) begin
                    if (op == ACC) begin
                        acc_q[c] <= acc_w[ACC_WIDTH-1:0];
                    end else if (op == CLR) begin
                        acc_q[c] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                busy_cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (accept && (in_ch == CH_W'(c)) && !(pop && (head.ch == CH_W'(c)))) begin
                    busy_cnt_q[c] <= busy_cnt_q[c] + CNT_W'(1);
                end else if (!(accept && (in_ch == CH_W'(c))) && pop && (head.ch == CH_W'(c))) begin
                    busy_cnt_q[c] <= busy_cnt_q[c] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        acc_busy = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            acc_busy[c] = (busy_cnt_q[c] != '0);
        end
    end

    add_res_fifo #(
        .Depth (FIFO_DEPTH),
        .T     (res_t)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (s1_valid_q),
        .data_i  (s1_q),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign out_ch  = head.ch;
    assign out_sum = head.sum;
    assign out_ovf = head.ovf;

`ifndef SYNTHESIS
    stalled_input_stable: assert property (@(posedge clock) disable iff (reset)
        (in_valid && !in_ready) |=> (in_valid && $stable({in_ch, in_op, in_a, in_b})));
`endif

endmodule
